// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/flush sequencer for the 5-stage pipelined CPU. Turns load-use
// hazards, taken branches and multi-cycle data-memory waits into per-stage
// write-enable / bubble controls for PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
// The pipeline only advances while start_i is high. Stall and flush
// performance counters are optional and saturate at their maximum value.
//
// Build option:
//   PIPE_PERF_CNT_EN  defined   -> saturating stall/flush counters present
//                     undefined -> no counters, stall_cnt_o = flush_cnt_o = 0
//
// Parameters:
//   CNT_W        width of the stall/flush performance counters
//   MEM_TIMEOUT  longest MEM_WAIT before the wait is abandoned (>= 2)
//
// Ports:
//   clk_i           rising-edge clock
//   rst_i           asynchronous reset, active low
//   start_i         run enable
//   idex_memread_i  ID_EX holds a load
//   idex_rd_i       ID_EX destination register
//   ifid_rs1_i      IF_ID source register 1
//   ifid_rs2_i      IF_ID source register 2
//   branch_taken_i  branch resolved taken in ID this cycle
//   mem_req_i       EX_MEM data-memory access in progress
//   mem_ack_i       data memory completes the access this cycle
//   pc_write_o      PC load enable
//   ifid_write_o    IF_ID load enable
//   ifid_flush_o    IF_ID clear to NOP
//   idex_bubble_o   ID_EX loads zeroed control
//   exmem_hold_o    EX_MEM holds its contents
//   memwb_bubble_o  MEM_WB loads RegWrite=0
//   state_o         0 IDLE, 1 RUN, 2 MEM_WAIT
//   timeout_o       sticky flag: a MEM_WAIT timed out (cleared by reset only)
//   stall_cnt_o     stall cycle count
//   flush_cnt_o     flush cycle count
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_hold_o,
  output logic             memwb_bubble_o,
  output logic [1:0]       state_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  // The wait counter must be able to hold MEM_TIMEOUT-1.
  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_FIRST = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

  // Which RUN-state rule wins this cycle, highest priority first.
  typedef enum logic [1:0] {
    RC_MEM,
    RC_BRANCH,
    RC_HAZARD,
    RC_PASS
  } run_case_e;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;

  logic      hazard;
  logic      mem_stall;
  run_case_e run_case;

  // ---------------------------------------------------------------------------
  // Hazard decode and RUN-state priority
  // ---------------------------------------------------------------------------
  always_comb begin
    hazard    = idex_memread_i && (idex_rd_i != 5'd0) &&
                ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
    mem_stall = mem_req_i && !mem_ack_i;

    // A branch flush discards the dependent instruction in IF_ID, so a
    // coincident load-use hazard needs no stall.
    if (mem_stall)           run_case = RC_MEM;
    else if (branch_taken_i) run_case = RC_BRANCH;
    else if (hazard)         run_case = RC_HAZARD;
    else                     run_case = RC_PASS;
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: state flops use non-blocking assignments and the asynchronous reset
  // in the sensitivity list, so every flop samples the pre-edge value and a
  // reset assertion takes effect without waiting for a clock.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (run_case == RC_MEM) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_FIRST;
        end else if (!start_i) begin
          state_d = ST_IDLE;
        end
      end

      // start_i is deliberately ignored until the wait resolves.
      ST_MEM_WAIT: begin
        if (mem_ack_i) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d   = ST_RUN;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_write_o     = 1'b0;
    ifid_write_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_hold_o   = 1'b0;
    memwb_bubble_o = 1'b0;

    unique case (state_q)
      // Idle keeps injecting bubbles so nothing half-decoded can retire.
      ST_IDLE: idex_bubble_o = 1'b1;

      ST_RUN: begin
        unique case (run_case)
          RC_MEM: begin
            exmem_hold_o   = 1'b1;
            memwb_bubble_o = 1'b1;
          end
          RC_BRANCH: begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b1;
          end
          RC_HAZARD: idex_bubble_o = 1'b1;
          RC_PASS: begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
          end
          default: ;
        endcase
      end

      // Frozen exactly like the cycle that entered the wait, including the
      // cycle on which the acknowledge arrives.
      ST_MEM_WAIT: begin
        exmem_hold_o   = 1'b1;
        memwb_bubble_o = 1'b1;
      end

      default: idex_bubble_o = 1'b1;
    endcase
  end

  assign state_o   = state_q;
  assign timeout_o = timeout_q;

  // ---------------------------------------------------------------------------
  // Optional saturating performance counters
  // ---------------------------------------------------------------------------
`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             stall_inc;
  logic             flush_inc;

  always_comb begin
    stall_inc = (state_q == ST_MEM_WAIT) ||
                ((state_q == ST_RUN) && (run_case == RC_HAZARD));
    flush_inc = (state_q == ST_RUN) && (run_case == RC_BRANCH);

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_inc && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed bench for pipeline_hazard_ctrl. Three instances share one stimulus:
//   dut      default parameters
//   dut_to   MEM_TIMEOUT = 4, used for the wait-timeout scenario
//   dut_sat  CNT_W = 2, used for counter saturation
// Control outputs of dut are packed as
//   {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, memwb_bubble}.
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

`ifdef PIPE_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  localparam logic [5:0] C_IDLE   = 6'b000100;
  localparam logic [5:0] C_PASS   = 6'b110000;
  localparam logic [5:0] C_HAZARD = 6'b000100;
  localparam logic [5:0] C_BRANCH = 6'b111000;
  localparam logic [5:0] C_MEM    = 6'b000011;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       idex_memread_i = 1'b0;
  logic [4:0] idex_rd_i = '0;
  logic [4:0] ifid_rs1_i = '0;
  logic [4:0] ifid_rs2_i = '0;
  logic       branch_taken_i = 1'b0;
  logic       mem_req_i = 1'b0;
  logic       mem_ack_i = 1'b0;

  logic        pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o;
  logic        exmem_hold_o, memwb_bubble_o, timeout_o;
  logic [1:0]  state_o;
  logic [15:0] stall_cnt_o, flush_cnt_o;

  logic        pc_write_t, ifid_write_t, ifid_flush_t, idex_bubble_t;
  logic        exmem_hold_t, memwb_bubble_t, timeout_t;
  logic [1:0]  state_t;
  logic [15:0] stall_cnt_t, flush_cnt_t;

  logic        pc_write_s, ifid_write_s, ifid_flush_s, idex_bubble_s;
  logic        exmem_hold_s, memwb_bubble_s, timeout_s;
  logic [1:0]  state_s;
  logic [1:0]  stall_cnt_s, flush_cnt_s;

  logic [5:0] ctrl;
  assign ctrl = {pc_write_o, ifid_write_o, ifid_flush_o,
                 idex_bubble_o, exmem_hold_o, memwb_bubble_o};

  int n_vec = 0;
  int n_err = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipeline_hazard_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(pc_write_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
    .idex_bubble_o(idex_bubble_o), .exmem_hold_o(exmem_hold_o),
    .memwb_bubble_o(memwb_bubble_o), .state_o(state_o), .timeout_o(timeout_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) dut_to (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(pc_write_t), .ifid_write_o(ifid_write_t), .ifid_flush_o(ifid_flush_t),
    .idex_bubble_o(idex_bubble_t), .exmem_hold_o(exmem_hold_t),
    .memwb_bubble_o(memwb_bubble_t), .state_o(state_t), .timeout_o(timeout_t),
    .stall_cnt_o(stall_cnt_t), .flush_cnt_o(flush_cnt_t)
  );

  pipeline_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(64)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
    .ifid_rs1_i(ifid_rs1_i), .ifid_rs2_i(ifid_rs2_i),
    .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .pc_write_o(pc_write_s), .ifid_write_o(ifid_write_s), .ifid_flush_o(ifid_flush_s),
    .idex_bubble_o(idex_bubble_s), .exmem_hold_o(exmem_hold_s),
    .memwb_bubble_o(memwb_bubble_s), .state_o(state_s), .timeout_o(timeout_s),
    .stall_cnt_o(stall_cnt_s), .flush_cnt_o(flush_cnt_s)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    idex_memread_i = 1'b0;
    idex_rd_i      = '0;
    ifid_rs1_i     = '0;
    ifid_rs2_i     = '0;
    branch_taken_i = 1'b0;
    mem_req_i      = 1'b0;
    mem_ack_i      = 1'b0;
  endtask

  // Reset all instances and bring them into RUN.
  task automatic do_reset();
    clear_inputs();
    start_i = 1'b0;
    rst_i   = 1'b0;
    #1;
    tick();
    rst_i   = 1'b1;
    start_i = 1'b1;
    tick();
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    start_i = 1'b0;
    rst_i   = 1'b0;
    #1;
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_vec++; if (ctrl !== C_IDLE) begin n_err++; $display("FAIL reset_ctrl: got %b want %b", ctrl, C_IDLE); end
    n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b want 0", timeout_o); end
    n_vec++; if (stall_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt_o); end
    n_vec++; if (flush_cnt_o !== 16'd0) begin n_err++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt_o); end

    tick();
    rst_i   = 1'b1;
    start_i = 1'b1;
    #1;
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL idle_before_edge: got %0d want 0", state_o); end
    tick();
    n_vec++; if (state_o !== 2'd1) begin n_err++; $display("FAIL idle_to_run: got %0d want 1", state_o); end
    n_vec++; if (ctrl !== C_PASS) begin n_err++; $display("FAIL run_pass_ctrl: got %b want %b", ctrl, C_PASS); end

    // Reset asserted mid-RUN while a memory stall is being requested.
    mem_req_i = 1'b1;
    #1;
    n_vec++; if (ctrl !== C_MEM) begin n_err++; $display("FAIL run_mem_ctrl: got %b want %b", ctrl, C_MEM); end
    rst_i = 1'b0;
    #1;
    n_vec++; if (state_o !== 2'd0) begin n_err++; $display("FAIL async_reset_state: got %0d want 0", state_o); end
    n_vec++; if (ctrl !== C_IDLE) begin n_err++; $display("FAIL async_reset_ctrl: got %b want %b", ctrl, C_IDLE); end
    n_vec++; if (stall_cnt_o !== 16'd0 || flush_cnt_o !== 16'd0) begin
      n_err++; $display("FAIL async_reset_cnt: got %0d/%0d want 0/0", stall_cnt_o, flush_cnt_o);
    end
    tick();
    rst_i     = 1'b1;
    mem_req_i = 1'b0;
    start_i   = 1'b1;
    tick();
    n_vec++; if (state_o !== 2'd1) begin n_err++; $display("FAIL restart_run: got %0d want 1", state_o); end
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_load_use();
    idex_memread_i = 1'b1; idex_rd_i = 5'd5; ifid_rs1_i = 5'd0; ifid_rs2_i = 5'd5;
    #1;
    n_vec++; if (ctrl !== C_HAZARD) begin n_err++; $display("FAIL hazard_rs2_ctrl: got %b want %b", ctrl, C_HAZARD); end
    tick();
    exp_stall++;
    clear_inputs();
    #1;
    n_vec++; if (stall_cnt_o !== 16'(exp_stall * PERF)) begin
      n_err++; $display("FAIL hazard_rs2_cnt: got %0d want %0d", stall_cnt_o, exp_stall * PERF);
    end
    n_vec++; if (ctrl !== C_PASS) begin n_err++; $display("FAIL hazard_release_ctrl: got %b want %b", ctrl, C_PASS); end

    // Destination x0 never creates a hazard.
    idex_memread_i = 1'b1; idex_rd_i = 5'd0;
    #1;
    n_vec++; if (ctrl !== C_PASS) begin n_err++; $display("FAIL rd0_ctrl: got %b want %b", ctrl, C_PASS); end
    tick();
    n_vec++; if (stall_cnt_o !== 16'(exp_stall * PERF)) begin
      n_err++; $display("FAIL rd0_cnt: got %0d want %0d", stall_cnt_o, exp_stall * PERF);
    end
    clear_inputs();

    idex_memread_i = 1'b1; idex_rd_i = 5'd7; ifid_rs1_i = 5'd7; ifid_rs2_i = 5'd3;
    #1;
    n_vec++; if (ctrl !== C_HAZARD) begin n_err++; $display("FAIL hazard_rs1_ctrl: got %b want %b", ctrl, C_HAZARD); end
    tick();
    exp_stall++;
    n_vec++; if (stall_cnt_o !== 16'(exp_stall * PERF)) begin
      n_err++; $display("FAIL hazard_rs1_cnt: got %0d want %0d", stall_cnt_o, exp_stall * PERF);
    end

    // Register match without a load is not a hazard.
    idex_memread_i = 1'b0;
    #1;
    n_vec++; if (ctrl !== C_PASS) begin n_err++; $display("FAIL no_load_ctrl: got %b want %b", ctrl, C_PASS); end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch();
    idex_memread_i = 1'b1; idex_rd_i = 5'd3; ifid_rs1_i = 5'd3; branch_taken_i = 1'b1;
    #1;
    n_vec++; if (ctrl !== C_BRANCH) begin n_err++; $display("FAIL branch_ctrl: got %b want %b", ctrl, C_BRANCH); end
    tick();
    exp_flush++;
    clear_inputs();
    #1;
    n_vec++; if (flush_cnt_o !== 16'(exp_flush * PERF)) begin
      n_err++; $display("FAIL branch_flush_cnt: got %0d want %0d", flush_cnt_o, exp_flush * PERF);
    end
    n_vec++; if (stall_cnt_o !== 16'(exp_stall * PERF)) begin
      n_err++; $display("FAIL branch_stall_cnt: got %0d want %0d", stall_cnt_o, exp_stall * PERF);
    end
    n_vec++; if (state_o !== 2'd1) begin n_err++; $display("FAIL branch_state: got %0d want 1", state_o); end
  endtask

  task automatic test_mem_wait();
    mem_req_i = 1'b1;
    #1;
    n_vec++; if (ctrl !== C_MEM || state_o !== 2'd1) begin
      n_err++; $display("FAIL mem_entry: got ctrl %b state %0d want %b state 1", ctrl, state_o, C_MEM);
    end
    for (int c = 1; c <= 3; c++) begin
      tick();
      // Mid-wait: branch and start_i=0 must not disturb the freeze.
      if (c == 2) begin branch_taken_i = 1'b1; start_i = 1'b0; end
      if (c == 3) begin branch_taken_i = 1'b0; start_i = 1'b1; mem_ack_i = 1'b1; end
      #1;
      exp_stall++;
      n_vec++; if (state_o !== 2'd2) begin n_err++; $display("FAIL mem_wait_state_c%0d: got %0d want 2", c, state_o); end
      n_vec++; if (ctrl !== C_MEM) begin n_err++; $display("FAIL mem_wait_ctrl_c%0d: got %b want %b", c, ctrl, C_MEM); end
    end
    tick();
    clear_inputs();
    #1;
    n_vec++; if (state_o !== 2'd1) begin n_err++; $display("FAIL mem_exit_state: got %0d want 1", state_o); end
    n_vec++; if (ctrl !== C_PASS) begin n_err++; $display("FAIL mem_exit_ctrl: got %b want %b", ctrl, C_PASS); end
    n_vec++; if (stall_cnt_o !== 16'(exp_stall * PERF)) begin
      n_err++; $display("FAIL mem_wait_cnt: got %0d want %0d", stall_cnt_o, exp_stall * PERF);
    end
    n_vec++; if (timeout_o !== 1'b0 || timeout_t !== 1'b0) begin
      n_err++; $display("FAIL mem_ack_timeout: got %b/%b want 0/0", timeout_o, timeout_t);
    end
  endtask

  task automatic test_timeout();
    mem_req_i = 1'b1;
    tick();
    tick();
    tick();
    n_vec++; if (state_t !== 2'd2 || timeout_t !== 1'b0) begin
      n_err++; $display("FAIL to_cycle3: got state %0d timeout %b want 2/0", state_t, timeout_t);
    end
    tick();
    mem_req_i = 1'b0;
    n_vec++; if (state_t !== 2'd1 || timeout_t !== 1'b1) begin
      n_err++; $display("FAIL to_expire: got state %0d timeout %b want 1/1", state_t, timeout_t);
    end
    n_vec++; if (state_o !== 2'd2 || timeout_o !== 1'b0) begin
      n_err++; $display("FAIL to_long_wait: got state %0d timeout %b want 2/0", state_o, timeout_o);
    end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_vec++; if (timeout_t !== 1'b1) begin n_err++; $display("FAIL to_sticky_%0d: got %b want 1", c, timeout_t); end
    end
    n_vec++; if (state_o !== 2'd1 || timeout_o !== 1'b0) begin
      n_err++; $display("FAIL to_default_after: got state %0d timeout %b want 1/0", state_o, timeout_o);
    end
    do_reset();
    n_vec++; if (timeout_t !== 1'b0) begin n_err++; $display("FAIL to_reset_clear: got %b want 0", timeout_t); end
  endtask

  task automatic test_saturate();
    idex_memread_i = 1'b1; idex_rd_i = 5'd9; ifid_rs1_i = 5'd9;
    for (int k = 1; k <= 5; k++) begin
      tick();
      exp_stall++;
      n_vec++; if (stall_cnt_s !== 2'(((k > 3) ? 3 : k) * PERF)) begin
        n_err++; $display("FAIL sat_cnt_%0d: got %0d want %0d", k, stall_cnt_s, ((k > 3) ? 3 : k) * PERF);
      end
      n_vec++; if (stall_cnt_o !== 16'(exp_stall * PERF)) begin
        n_err++; $display("FAIL wide_cnt_%0d: got %0d want %0d", k, stall_cnt_o, exp_stall * PERF);
      end
    end
    clear_inputs();
    tick();
    n_vec++; if (stall_cnt_s !== 2'(3 * PERF) || flush_cnt_s !== 2'd0) begin
      n_err++; $display("FAIL sat_hold: got %0d/%0d want %0d/0", stall_cnt_s, flush_cnt_s, 3 * PERF);
    end
  endtask

  task automatic test_idle_return();
    idex_memread_i = 1'b1; idex_rd_i = 5'd4; ifid_rs2_i = 5'd4; start_i = 1'b0;
    #1;
    n_vec++; if (state_o !== 2'd1 || ctrl !== C_HAZARD) begin
      n_err++; $display("FAIL stop_last_run: got state %0d ctrl %b want 1 %b", state_o, ctrl, C_HAZARD);
    end
    tick();
    exp_stall++;
    n_vec++; if (state_o !== 2'd0 || ctrl !== C_IDLE) begin
      n_err++; $display("FAIL stop_idle: got state %0d ctrl %b want 0 %b", state_o, ctrl, C_IDLE);
    end
    n_vec++; if (stall_cnt_o !== 16'(exp_stall * PERF)) begin
      n_err++; $display("FAIL stop_cnt: got %0d want %0d", stall_cnt_o, exp_stall * PERF);
    end
    mem_req_i = 1'b1;
    tick();
    n_vec++; if (state_o !== 2'd0 || ctrl !== C_IDLE) begin
      n_err++; $display("FAIL idle_ignores_mem: got state %0d ctrl %b want 0 %b", state_o, ctrl, C_IDLE);
    end
    n_vec++; if (stall_cnt_o !== 16'(exp_stall * PERF)) begin
      n_err++; $display("FAIL idle_no_count: got %0d want %0d", stall_cnt_o, exp_stall * PERF);
    end
    clear_inputs();
    start_i = 1'b1;
    tick();
    n_vec++; if (state_o !== 2'd1) begin n_err++; $display("FAIL idle_restart: got %0d want 1", state_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_saturate();
    test_idle_return();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
